// File: rtl/pool_unit_mc.sv
// Multi-channel streaming pooling unit: reduces channel-interleaved signed samples
// over a 2^LOG2_WIN window per channel (average or max), then drains one result per channel.
module pool_unit_mc #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned CH       = 4,
    parameter int unsigned LOG2_WIN = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   mode,
    input  logic                                   flush,
    input  logic [DATA_W-1:0]                      in_data,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    output logic [DATA_W-1:0]                      out_data,
    output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] out_ch,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   busy
);

    localparam int unsigned CW  = (CH > 1) ? $clog2(CH) : 1;
    localparam int unsigned AW  = DATA_W + LOG2_WIN;
    localparam int unsigned WIN = 1 << LOG2_WIN;

    typedef enum logic {ACCUM, DRAIN} state_t;

    state_t               state, state_d;
    logic [CW-1:0]        ch_cnt;
    logic [LOG2_WIN-1:0]  win_cnt;
    logic signed [AW-1:0] acc [CH];
    logic                 mode_q;

    logic                 in_xfer, out_xfer, last_in, last_out;
    logic signed [AW-1:0] sx, cur, acc_d, drain_acc;
    logic [CW-1:0]        drain_idx;
    logic [DATA_W-1:0]    drain_res;

    assign in_xfer  = in_valid && in_ready && !flush && (state == ACCUM);
    assign last_in  = in_xfer && (ch_cnt == CW'(CH - 1)) && (win_cnt == LOG2_WIN'(WIN - 1));
    assign out_xfer = out_valid && out_ready;
    assign last_out = out_xfer && (out_ch == CW'(CH - 1));

    // Next-state logic; flush overrides everything
    always_comb begin
        state_d = state;
        case (state)
            ACCUM:   if (last_in)  state_d = DRAIN;
            DRAIN:   if (last_out) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
        if (flush) state_d = ACCUM;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACCUM;
        else     state <= state_d;
    end

    // Per-channel reduction; the first sample of a window needs no mode, so mode_q can load alongside it
    always_comb begin
        sx  = {{LOG2_WIN{in_data[DATA_W-1]}}, in_data};
        cur = acc[ch_cnt];
        if (win_cnt == '0)  acc_d = sx;
        else if (mode_q)    acc_d = (sx > cur) ? sx : cur;
        else                acc_d = cur + sx;
    end

    always_comb begin
        drain_idx = out_valid ? (out_ch + CW'(1)) : '0;
        drain_acc = acc[drain_idx];
        drain_res = mode_q ? DATA_W'(drain_acc) : DATA_W'(drain_acc >>> LOG2_WIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            busy      <= 1'b0;
            ch_cnt    <= '0;
            win_cnt   <= '0;
            mode_q    <= 1'b0;
            for (int i = 0; i < CH; i++) acc[i] <= '0;
        end else begin
            in_ready <= (state_d == ACCUM);
            if (flush) begin
                out_valid <= 1'b0;
                busy      <= 1'b0;
                ch_cnt    <= '0;
                win_cnt   <= '0;
            end else begin
                if (in_xfer) begin
                    busy         <= 1'b1;
                    acc[ch_cnt]  <= acc_d;
                    if (ch_cnt == '0 && win_cnt == '0) mode_q <= mode;
                    if (ch_cnt == CW'(CH - 1)) begin
                        ch_cnt  <= '0;
                        win_cnt <= win_cnt + LOG2_WIN'(1);
                    end else begin
                        ch_cnt  <= ch_cnt + CW'(1);
                    end
                end
                // Present the next channel on entry or after each accepted result
                if (state == DRAIN && (!out_valid || out_xfer)) begin
                    if (last_out) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        out_valid <= 1'b1;
                        out_ch    <= drain_idx;
                        out_data  <= drain_res;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pool_unit_mc.sv
// Scoreboard bench for pool_unit_mc: a 32-bit 2-channel instance for function/handshake
// and an 8-bit 2-channel instance for numeric extremes.
module tb_pool_unit_mc;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_mode, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [31:0] a_in_data, a_out_data;
    logic [0:0]  a_out_ch;
    logic        b_mode, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [7:0]  b_in_data, b_out_data;
    logic [0:0]  b_out_ch;

    pool_unit_mc #(.DATA_W(32), .CH(2), .LOG2_WIN(2)) dut_a (
        .clk(clk), .rst(rst), .mode(a_mode), .flush(a_flush),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_ch(a_out_ch), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .busy(a_busy));

    pool_unit_mc #(.DATA_W(8), .CH(2), .LOG2_WIN(2)) dut_b (
        .clk(clk), .rst(rst), .mode(b_mode), .flush(b_flush),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_ch(b_out_ch), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .busy(b_busy));

    typedef struct {
        logic [0:0]  ch;
        logic [31:0] data;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic int model(input int s[4], input logic m);
        longint acc = longint'(s[0]);
        for (int i = 1; i < 4; i++) begin
            if (m) acc = (longint'(s[i]) > acc) ? longint'(s[i]) : acc;
            else   acc = acc + longint'(s[i]);
        end
        return m ? int'(acc) : int'(acc >>> 2);
    endfunction

    // Score any output transfer about to happen, then advance one cycle to the next falling edge
    task automatic step();
        exp_t e;
        if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) chk("a_spurious_out", 32'(a_out_valid), 32'd0);
            else begin
                e = qa.pop_front();
                chk("a_out_ch", 32'(a_out_ch), 32'(e.ch));
                chk("a_out_data", a_out_data, e.data);
            end
        end
        if (b_out_valid && b_out_ready) begin
            if (qb.size() == 0) chk("b_spurious_out", 32'(b_out_valid), 32'd0);
            else begin
                e = qb.pop_front();
                chk("b_out_ch", 32'(b_out_ch), 32'(e.ch));
                chk("b_out_data", {24'd0, b_out_data}, {24'd0, e.data[7:0]});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_a(input int d);
        logic ok = 1'b0;
        a_in_valid = 1'b1;
        a_in_data  = 32'(d);
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = a_in_ready && !a_flush;
            step();
        end
        if (!ok) chk("a_send_timeout", 32'(ok), 32'd1);
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input int d);
        logic ok = 1'b0;
        b_in_valid = 1'b1;
        b_in_data  = 8'(d);
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = b_in_ready && !b_flush;
            step();
        end
        if (!ok) chk("b_send_timeout", 32'(ok), 32'd1);
        b_in_valid = 1'b0;
    endtask

    task automatic win_a(input int c0[4], input int c1[4], input logic m, input bit toggle);
        exp_t e;
        a_mode = m;
        e.ch = 1'b0; e.data = 32'(model(c0, m)); qa.push_back(e);
        e.ch = 1'b1; e.data = 32'(model(c1, m)); qa.push_back(e);
        for (int k = 0; k < 4; k++) begin
            send_a(c0[k]);
            if (toggle && k == 1) a_mode = ~m;
            send_a(c1[k]);
        end
    endtask

    task automatic win_b(input int c0[4], input int c1[4], input logic m);
        exp_t e;
        b_mode = m;
        e.ch = 1'b0; e.data = 32'(model(c0, m)); qb.push_back(e);
        e.ch = 1'b1; e.data = 32'(model(c1, m)); qb.push_back(e);
        for (int k = 0; k < 4; k++) begin
            send_b(c0[k]);
            send_b(c1[k]);
        end
    endtask

    task automatic drain_all(input string tag);
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
            step();
            n++;
        end
        chk({tag, "_drain_timeout"}, 32'(qa.size() + qb.size()), 32'd0);
        chk({tag, "_busy_idle"}, 32'(a_busy), 32'd0);
        chk({tag, "_in_ready_idle"}, 32'(a_in_ready), 32'd1);
    endtask

    int c0[4], c1[4];

    initial begin
        rst = 1'b1;
        a_mode = 0; a_flush = 0; a_in_valid = 0; a_in_data = '0; a_out_ready = 1;
        b_mode = 0; b_flush = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 1;
        #12;
        chk("rst_in_ready", 32'(a_in_ready), 32'd0);
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_out_data", a_out_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", 32'(a_in_ready), 32'd1);

        // Average, with latency check around the final transfer
        c0 = '{4, 8, 12, 16};
        c1 = '{-1, -2, -3, -4};
        win_a(c0, c1, 1'b0, 1'b0);
        chk("lat_out_valid_c1", 32'(a_out_valid), 32'd0);
        chk("lat_in_ready_drain", 32'(a_in_ready), 32'd0);
        chk("lat_busy", 32'(a_busy), 32'd1);
        step();
        chk("lat_out_valid_c2", 32'(a_out_valid), 32'd1);
        drain_all("avg");

        // Max, mode toggled mid-window must be ignored
        win_a(c0, c1, 1'b1, 1'b1);
        drain_all("max_toggle");

        // Backpressure holds the first result stable
        a_out_ready = 1'b0;
        win_a(c0, c1, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 32'(a_out_valid), 32'd1);
            chk("bp_out_data", a_out_data, 32'd10);
            chk("bp_out_ch", 32'(a_out_ch), 32'd0);
            chk("bp_in_ready", 32'(a_in_ready), 32'd0);
            step();
        end
        a_out_ready = 1'b1;
        step();
        chk("bp_second_valid", 32'(a_out_valid), 32'd1);
        chk("bp_second_ch", 32'(a_out_ch), 32'd1);
        drain_all("bp");

        // 8-bit extremes: average cannot overflow, max is signed
        c0 = '{127, 127, 127, 127};
        c1 = '{-128, -128, -128, -128};
        win_b(c0, c1, 1'b0);
        c0 = '{-128, -128, -128, -127};
        c1 = '{5, -3, 7, 0};
        win_b(c0, c1, 1'b1);
        drain_all("extremes");

        // Flush after 5 transfers; the input in the flush cycle must be dropped
        a_mode = 1'b0;
        for (int i = 0; i < 5; i++) send_a(100 + i);
        a_flush = 1'b1; a_in_valid = 1'b1; a_in_data = 32'd99;
        step();
        a_flush = 1'b0; a_in_valid = 1'b0;
        chk("flush_busy", 32'(a_busy), 32'd0);
        chk("flush_out_valid", 32'(a_out_valid), 32'd0);
        chk("flush_in_ready", 32'(a_in_ready), 32'd1);
        c0 = '{1, 1, 1, 1};
        c1 = '{2, 2, 2, 2};
        win_a(c0, c1, 1'b0, 1'b0);
        drain_all("post_flush");

        // Reset during drain clears outputs asynchronously
        a_out_ready = 1'b0;
        c0 = '{4, 8, 12, 16};
        c1 = '{-1, -2, -3, -4};
        win_a(c0, c1, 1'b0, 1'b0);
        step();
        chk("pre_rst_out_valid", 32'(a_out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(a_out_valid), 32'd0);
        chk("arst_busy", 32'(a_busy), 32'd0);
        chk("arst_out_data", a_out_data, 32'd0);
        qa.delete();
        #2;
        rst = 1'b0;
        a_out_ready = 1'b1;
        step();
        c0 = '{-7, 3, 20, -1};
        c1 = '{9, 9, -30, 40};
        win_a(c0, c1, 1'b0, 1'b0);
        drain_all("post_rst");
        win_a(c0, c1, 1'b1, 1'b0);
        drain_all("post_rst_max");

        for (int i = 0; i < 3; i++) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pool_unit_mc.md
Name: pool_unit_mc

Overview:
- Parametrised, multi-channel streaming pooling unit for the CNN core. Successor to the single-channel fixed 4-sample averager.
- Accepts channel-interleaved signed samples on a valid/ready input and reduces each channel over a window of 2^LOG2_WIN samples. Reduction is average or max, selected by mode.
- Emits one result per channel, in channel order, on a valid/ready output with backpressure.
- Sits between the layer-2 convolution output stream and the classifier/FC input stream.

Parameters:
- DATA_W, 32, width of signed input samples and output results.
- CH, 4, number of interleaved channels (>=1).
- LOG2_WIN, 2, log2 of samples per channel per window (window = 1<<LOG2_WIN, >=1).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  1  0 = average, 1 = max; sampled only at window start.
- flush  input  1  synchronous abort: discards the partial window and returns to ACCUM at channel 0.
- in_data  input  DATA_W  signed sample for the current channel.
- in_valid  input  1  in_data valid.
- in_ready  output  1  unit can accept in_data this cycle.
- out_data  output  DATA_W  signed pooled result.
- out_ch  output  clog2(CH) (min 1)  channel index of out_data.
- out_valid  output  1  out_data/out_ch valid.
- out_ready  input  1  downstream accepts output.
- busy  output  1  a window is in progress or results are pending.

Behaviour:
- Reset values (async, immediate): in_ready=0 until first clk edge after rst deasserts (then 1); out_valid=0, out_data=0, out_ch=0, busy=0; all counters and accumulators 0; state=ACCUM; mode_q=0.
- Input transfer: in_valid && in_ready on a rising edge. Output transfer: out_valid && out_ready.
- Sample ordering: ch0,ch1,…,ch(CH-1) repeated WIN times. An internal ch_cnt (0..CH-1) and win_cnt (0..WIN-1) track position. ch_cnt wraps to 0 and increments win_cnt.
- State ACCUM:
  - in_ready=1.
  - On the first accepted sample of a window (ch_cnt=0, win_cnt=0), mode is latched into mode_q.
  - Per channel, at win_cnt=0: acc[ch] <= sample (avg: sign-extended to DATA_W+LOG2_WIN bits; max: the sample itself).
  - At win_cnt>0: avg acc[ch] <= acc[ch] + sext(sample); max acc[ch] <= (sample > acc[ch]) ? sample : acc[ch], signed compare.
  - The transfer with ch_cnt=CH-1 and win_cnt=WIN-1 moves to DRAIN next cycle. busy=1 from the first accepted sample.
- State DRAIN:
  - in_ready=0. Results are presented for ch 0..CH-1 sequentially; out_valid=1 registered, appearing the cycle after entry.
  - avg result = acc[ch] >>> LOG2_WIN (arithmetic, floor toward -inf), truncated to DATA_W; cannot overflow.
  - max result = acc[ch].
  - out_data/out_ch hold stable while out_valid && !out_ready.
  - On a transfer of the last channel, the unit returns to ACCUM with out_valid=0, busy=0 and counters at 0. in_ready=1 the following cycle.
  - Latency: last input transfer to first out_valid = 2 cycles. Zero-stall drain = CH cycles.
- Output handshake: out_valid never drops without a transfer, except on rst or flush.
- flush:
  - Highest priority after rst; any state.
  - Next cycle: state=ACCUM, counters=0, out_valid=0, busy=0. Pending results are dropped.
  - An input presented in the same cycle as flush is not accepted.
- mode change mid-window: ignored until the next window start.
- rst mid-window or mid-drain: all state cleared immediately. No partial output is emitted.
- in_valid=0 gaps: the window simply pauses; there is no timeout.
- No $display in synthesizable RTL.

Test Plan:
- CH=2, LOG2_WIN=2, mode=0, stream ch0:{4,8,12,16}, ch1:{-1,-2,-3,-4} interleaved -> outputs (ch0,10) then (ch1,-3) [floor of -2.5]; out_valid first asserts 2 cycles after the 8th transfer.
- Same stream with mode=1 -> (ch0,16), (ch1,-1). Toggling mode to 0 after the 3rd transfer -> still max results.
- Backpressure: hold out_ready=0 for 5 cycles in DRAIN -> out_data=10, out_ch=0 stable, in_ready=0 throughout; release -> both results emitted on consecutive cycles.
- Extremes, DATA_W=8, avg of four 127 -> 127; avg of four -128 -> -128 (no overflow). Max of {-128,-128,-128,-127} -> -127.
- flush asserted after 5 transfers -> no output. A following full window {1,1,1,1}/{2,2,2,2} -> (ch0,1), (ch1,2).
- rst asserted mid-DRAIN with out_valid=1 -> out_valid, busy, out_data go 0 asynchronously; after release, a full new window produces correct results.
